// File: rtl/pipelined_alu_mdu.sv
// -----------------------------------------------------------------------------
// pipelined_alu_mdu
//
// Single-issue ALU with an iterative multiply/divide unit and MIPS-style HI/LO
// registers. Logic/arithmetic ops and HI/LO moves complete in one cycle;
// MULT/MULTU/DIV/DIVU iterate one bit per cycle for WIDTH cycles.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   reset        : asynchronous, active-high reset
//   start        : launch the operation on f/a/b (accepted in IDLE or DONE)
//   f[3:0]       : operation code
//   a, b         : operands, WIDTH bits
//   y            : registered result
//   zero         : registered (y == 0)
//   busy         : high while an iterative operation runs
//   done         : one-cycle pulse when y (and HI/LO where applicable) update
//   hi, lo       : architectural HI/LO registers
//   div_by_zero  : sticky flag for the last completed DIV/DIVU
// -----------------------------------------------------------------------------
module pipelined_alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       f,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_ZERO = 4'd3;
    localparam logic [3:0] OP_ANDN = 4'd4;
    localparam logic [3:0] OP_ORN  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MFHI = 4'd12;
    localparam logic [3:0] OP_MFLO = 4'd13;
    localparam logic [3:0] OP_MTHI = 4'd14;
    localparam logic [3:0] OP_MTLO = 4'd15;

    // Control state
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    // Iterative datapath state
    logic             op_mul;     // 1: multiply, 0: divide
    logic             div_zero;   // captured divisor was zero
    logic             neg_res;    // negate product / quotient at the end
    logic             neg_rem;    // negate remainder at the end
    logic [WIDTH-1:0] a_reg;      // original dividend, returned in hi on /0
    logic [WIDTH-1:0] mcand;      // |b|: multiplicand or divisor
    logic [WIDTH:0]   upper;      // partial product / partial remainder
    logic [WIDTH-1:0] lower;      // multiplier / dividend-quotient shifter

    // Request decode
    logic             accept;
    logic             is_iter;
    logic             op_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign accept    = start && (state != S_CALC);
    assign is_iter   = (f[3:2] == 2'b10);
    assign op_signed = ~f[0];   // MULT=8 and DIV=10 are the signed variants
    assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
    assign busy      = (state == S_CALC);

    // -------------------------------------------------------------------------
    // Single-cycle result
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] alu_y;

    always_comb begin
        // NOTE: default first so every path assigns alu_y; an incomplete
        // assignment in combinational logic would infer a latch.
        alu_y = '0;
        case (f)
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_ADD:  alu_y = a + b;
            OP_ZERO: alu_y = '0;
            OP_ANDN: alu_y = a & ~b;
            OP_ORN:  alu_y = a | ~b;
            OP_SUB:  alu_y = a - b;
            OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MFHI: alu_y = hi;
            OP_MFLO: alu_y = lo;
            default: alu_y = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // One iteration of shift-add multiply or restoring divide
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic [WIDTH:0]   upper_nxt;
    logic [WIDTH-1:0] lower_nxt;

    always_comb begin
        mul_sum   = upper + {1'b0, (lower[0] ? mcand : {WIDTH{1'b0}})};
        div_shift = {upper[WIDTH-1:0], lower[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand};
        div_ok    = ~div_diff[WIDTH+1];
        upper_nxt = upper;
        lower_nxt = lower;
        if (op_mul) begin
            // Add the multiplicand when the multiplier LSB is set, then shift
            // the whole {upper, lower} pair right by one.
            upper_nxt = {1'b0, mul_sum[WIDTH:1]};
            lower_nxt = {mul_sum[0], lower[WIDTH-1:1]};
        end else begin
            // Keep the trial subtraction only if it did not borrow; the
            // quotient bit shifts in from the right as the dividend leaves.
            upper_nxt = div_ok ? div_diff[WIDTH:0] : div_shift;
            lower_nxt = {lower[WIDTH-2:0], div_ok};
        end
    end

    // -------------------------------------------------------------------------
    // Final HI/LO from the last iteration, with sign correction
    // -------------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;

    always_comb begin
        prod   = {upper_nxt[WIDTH-1:0], lower_nxt};
        prod_s = neg_res ? -prod : prod;
        quo    = lower_nxt;
        rem    = upper_nxt[WIDTH-1:0];
        if (op_mul) begin
            fin_hi = prod_s[2*WIDTH-1:WIDTH];
            fin_lo = prod_s[WIDTH-1:0];
        end else if (div_zero) begin
            fin_hi = a_reg;
            fin_lo = '1;
        end else begin
            // Quotient truncates toward zero; remainder follows the dividend.
            fin_hi = neg_rem ? -rem : rem;
            fin_lo = neg_res ? -quo : quo;
        end
    end

    // -------------------------------------------------------------------------
    // Control and architectural state
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            y           <= '0;
            zero        <= 1'b1;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_iter) begin
                            state <= S_CALC;
                            cnt   <= '0;
                            if (f[1]) begin
                                div_by_zero <= 1'b0;
                            end
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            case (f)
                                OP_MTHI: hi <= a;
                                OP_MTLO: lo <= a;
                                default: begin
                                    y    <= alu_y;
                                    zero <= (alu_y == '0);
                                end
                            endcase
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    // start is ignored here: accept is never true in CALC.
                    if (cnt == LAST_STEP) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        hi    <= fin_hi;
                        lo    <= fin_lo;
                        y     <= fin_lo;
                        zero  <= (fin_lo == '0);
                        if (!op_mul) begin
                            div_by_zero <= div_zero;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the iterative datapath registers are not reset; they are always
    // loaded at the accepting edge before anything reads them.
    always_ff @(posedge clk) begin
        if (accept && is_iter) begin
            op_mul   <= ~f[1];
            div_zero <= (b == '0);
            neg_res  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem  <= op_signed && a[WIDTH-1];
            a_reg    <= a;
            mcand    <= b_mag;
            upper    <= '0;
            lower    <= a_mag;
        end else if (state == S_CALC) begin
            upper <= upper_nxt;
            lower <= lower_nxt;
        end
    end

endmodule

// File: tb/tb_pipelined_alu_mdu.sv
// -----------------------------------------------------------------------------
// tb_pipelined_alu_mdu
//
// Directed, table-driven bench for pipelined_alu_mdu at WIDTH=32. Each table
// entry carries one operation and the hand-computed y/hi/lo/div_by_zero that
// must be visible with done. Hand-written sequences cover back-to-back issue
// from DONE and a reset landing in the middle of a multiply.
// -----------------------------------------------------------------------------
module tb_pipelined_alu_mdu;

    localparam int W = 32;
    localparam int N_VEC = 23;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   f;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         zero;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    pipelined_alu_mdu #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .f           (f),
        .a           (a),
        .b           (b),
        .y           (y),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs [N_VEC];

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] prev_hi;
    logic [W-1:0] prev_lo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] vf, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [W-1:0] vy, input logic [W-1:0] vhi,
                                input logic [W-1:0] vlo, input logic vdbz);
        vec_t v;
        v.f = vf; v.a = va; v.b = vb; v.y = vy; v.hi = vhi; v.lo = vlo; v.dbz = vdbz;
        return v;
    endfunction

    // Issue one op from IDLE and check its completion.
    task automatic do_op(input int idx, input vec_t v);
        int c;
        int nb;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, "_done_low_before"}, done, 1'b0);
        f = v.f; a = v.a; b = v.b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs: the captured operands must be the ones used.
        f = 4'($urandom); a = $urandom; b = $urandom;
        if (v.f[3:2] == 2'b10) begin
            c  = 1;
            nb = 0;
            while (!done && c <= 40) begin
                nb += int'(busy);
                if (c == 16) begin
                    check({tag, "_hi_held"}, hi, prev_hi);
                    check({tag, "_lo_held"}, lo, prev_lo);
                end
                @(negedge clk);
                c++;
            end
            check({tag, "_latency"}, c, 33);
            check({tag, "_busy_cycles"}, nb, 32);
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_y"}, y, v.y);
        check({tag, "_zero"}, zero, (v.y == '0));
        check({tag, "_hi"}, hi, v.hi);
        check({tag, "_lo"}, lo, v.lo);
        check({tag, "_dbz"}, div_by_zero, v.dbz);
        prev_hi = v.hi;
        prev_lo = v.lo;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_y"}, y, '0);
        check({tag, "_zero"}, zero, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_hi"}, hi, '0);
        check({tag, "_lo"}, lo, '0);
        check({tag, "_dbz"}, div_by_zero, 1'b0);
    endtask

    initial begin
        int done_seen;

        //             f      a             b             y             hi            lo            dbz
        vecs[0]  = mk(4'd6,  32'd5,        32'd7,        32'hFFFFFFFE, 32'h0,        32'h0,        1'b0);
        vecs[1]  = mk(4'd0,  32'hF0,       32'h0F,       32'h0,        32'h0,        32'h0,        1'b0);
        vecs[2]  = mk(4'd1,  32'hF0,       32'h0F,       32'hFF,       32'h0,        32'h0,        1'b0);
        vecs[3]  = mk(4'd2,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'h0,        1'b0);
        vecs[4]  = mk(4'd3,  32'h123,      32'h456,      32'h0,        32'h0,        32'h0,        1'b0);
        vecs[5]  = mk(4'd4,  32'hFF,       32'h0F,       32'hF0,       32'h0,        32'h0,        1'b0);
        vecs[6]  = mk(4'd5,  32'h0,        32'hFFFFFFFE, 32'h1,        32'h0,        32'h0,        1'b0);
        vecs[7]  = mk(4'd7,  32'hFFFFFFFF, 32'd1,        32'h1,        32'h0,        32'h0,        1'b0);
        vecs[8]  = mk(4'd7,  32'd1,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        1'b0);
        vecs[9]  = mk(4'd14, 32'h1234,     32'h0,        32'h0,        32'h1234,     32'h0,        1'b0);
        vecs[10] = mk(4'd12, 32'h0,        32'h0,        32'h1234,     32'h1234,     32'h0,        1'b0);
        vecs[11] = mk(4'd15, 32'h5678,     32'h0,        32'h1234,     32'h1234,     32'h5678,     1'b0);
        vecs[12] = mk(4'd13, 32'h0,        32'h0,        32'h5678,     32'h1234,     32'h5678,     1'b0);
        vecs[13] = mk(4'd8,  32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        vecs[14] = mk(4'd9,  32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD, 32'h2,        32'hFFFFFFFD, 1'b0);
        vecs[15] = mk(4'd10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        vecs[16] = mk(4'd11, 32'd100,      32'd0,        32'hFFFFFFFF, 32'd100,      32'hFFFFFFFF, 1'b1);
        vecs[17] = mk(4'd2,  32'd1,        32'd2,        32'd3,        32'd100,      32'hFFFFFFFF, 1'b1);
        vecs[18] = mk(4'd10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        32'h80000000, 1'b0);
        vecs[19] = mk(4'd11, 32'd7,        32'd3,        32'd2,        32'd1,        32'd2,        1'b0);
        vecs[20] = mk(4'd8,  32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);
        vecs[21] = mk(4'd9,  32'h80000000, 32'd4,        32'h0,        32'h2,        32'h0,        1'b0);
        vecs[22] = mk(4'd10, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        32'hFFFFFFFD, 1'b0);

        reset = 1'b1; start = 1'b0; f = '0; a = '0; b = '0;
        prev_hi = '0; prev_lo = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            do_op(i, vecs[i]);
        end

        // Back-to-back: a new op accepted in DONE keeps done high.
        @(negedge clk);
        f = 4'd2; a = 32'd10; b = 32'd20; start = 1'b1;
        @(negedge clk);
        check("b2b_first_done", done, 1'b1);
        check("b2b_first_y", y, 32'h1E);
        f = 4'd13;
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_done", done, 1'b1);
        check("b2b_second_y", y, 32'hFFFFFFFD);
        @(negedge clk);
        check("b2b_done_drops", done, 1'b0);
        check("b2b_y_holds", y, 32'hFFFFFFFD);

        // MULT with an ignored mid-CALC start, then reset at cycle 20.
        @(negedge clk);
        f = 4'd8; a = 32'hFFFFFFFF; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_seen = 0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        f = 4'd2; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("midop_busy", busy, 1'b1);
        check("midop_done", done, 1'b0);
        check("midop_y", y, 32'hFFFFFFFD);
        for (int c = 12; c <= 20; c++) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        check("midop_no_done", done_seen, 0);
        check_reset_outputs("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_alu_mdu.md
PIPELINED_ALU_MDU -- requirements
Module: pipelined_alu_mdu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width in bits (legal values 8..64, even).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a request to launch the operation on f/a/b.
REQ-005 The block SHALL have port f, input, 4, the operation code.
REQ-006 The block SHALL have ports a and b, input, WIDTH, the operands.
REQ-007 The block SHALL have port y, output, WIDTH, the registered result.
REQ-008 The block SHALL have port zero, output, 1, high when y equals 0.
REQ-009 The block SHALL have port busy, output, 1, high while an iterative operation runs.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse when y (and HI/LO where applicable) is updated.
REQ-011 The block SHALL have ports hi and lo, output, WIDTH, the architectural HI/LO registers.
REQ-012 The block SHALL have port div_by_zero, output, 1, a sticky flag for the last completed DIV/DIVU; cleared by the next accepted DIV/DIVU.

Function
REQ-013 The f codes SHALL be: 0 a&b; 1 a|b; 2 a+b; 3 constant 0; 4 a&~b; 5 a|~b; 6 a-b; 7 signed a<b ? 1 : 0; 8 MULT; 9 MULTU; 10 DIV; 11 DIVU; 12 MFHI; 13 MFLO; 14 MTHI; 15 MTLO.
REQ-014 Add and subtract SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; start is accepted in IDLE or DONE only; start in CALC SHALL be ignored with no side effect.
REQ-016 Codes 0-7 and 12-13, when accepted at edge k, SHALL load y at edge k (y=hi for 12, y=lo for 13) and pulse done for the following cycle, giving latency 1; the state goes to DONE.
REQ-017 Codes 14/15 SHALL load hi (14) or lo (15) from a at edge k, leave y unchanged, and pulse done for the following cycle.
REQ-018 Codes 8-11 SHALL enter CALC for exactly WIDTH cycles with busy=1 (shift-add multiply, restoring divide, one bit per cycle), then enter DONE for one cycle with done=1 and busy=0, with hi, lo and y=lo updated on entry to DONE; done is therefore visible WIDTH+1 cycles after the accepting edge.
REQ-019 Operands SHALL be captured at the accepting edge; changes to a/b/f during CALC SHALL not affect the result.
REQ-020 MULT/MULTU SHALL produce the 2*WIDTH-bit signed/unsigned product; hi takes the upper half, lo the lower half.
REQ-021 DIV/DIVU SHALL set lo to the quotient and hi to the remainder; signed quotient truncates toward zero and remainder takes the sign of the dividend.
REQ-022 Signed DIV of the most negative value by -1 SHALL give lo = most negative value and hi = 0.
REQ-023 Divide by zero SHALL still take WIDTH+1 cycles and give lo = all ones, hi = a, and div_by_zero=1 at done.
REQ-024 hi and lo SHALL be unchanged during CALC; MFHI/MFLO cannot be issued during CALC because start is ignored there.
REQ-025 zero SHALL be registered alongside y and always equal (y==0).
REQ-026 DONE with no start SHALL return to IDLE; done SHALL never be high for two consecutive cycles unless a new op is accepted in DONE.

Reset
REQ-027 Asserting reset at any time, including mid-CALC, SHALL immediately force state IDLE, y=0, zero=1, busy=0, done=0, hi=0, lo=0 and div_by_zero=0, discarding any operation in progress.
REQ-028 The first start after reset deassertion SHALL be accepted at the first rising edge on which it is sampled high.

Verification (WIDTH=32)
REQ-029 f=6, a=5, b=7, start pulse -> next cycle y=0xFFFFFFFE, done=1, zero=0, busy never high.
REQ-030 f=8, a=0xFFFFFFFF, b=3 -> busy for 32 cycles, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFFD, y=lo; repeat with f=9 -> hi=0x00000002, lo=0xFFFFFFFD.
REQ-031 f=10, a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); f=11, a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1.
REQ-032 f=10, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 Start MULT, pulse start with f=2 at cycle 10 of CALC, assert reset at cycle 20 -> mid-op start ignored; after reset all outputs per REQ-027, no done pulse.
REQ-034 f=14 a=0x1234, then f=12 -> hi=0x1234 and y=0x1234 with one done pulse per op; f=0 a=0xF0 b=0x0F -> y=0, zero=1.
